// File: rtl/nash_pkg.sv
// nash_pkg: shared FSM encoding and sizing for the NASH byte-serial stream adapter.
`default_nettype none

package nash_pkg;

  localparam int NASH_BYTE_W = 8;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nash_state_e;

  function automatic int nash_idx_w(input int bw);
    return (bw > 1) ? $clog2(bw) : 1;
  endfunction

  localparam int NASH_IDX_W = nash_idx_w(NASH_BYTE_W);

endpackage

`default_nettype wire

// File: rtl/nash_byte_shifter.sv
// nash_byte_shifter: LSB-first plaintext shifter with cipher-bit collector and bit index.
`default_nettype none

module nash_byte_shifter
  import nash_pkg::*;
#(
  parameter int BYTE_W = NASH_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_ct_bit,
  output logic              o_pt_bit,
  output logic              o_last,
  output logic              o_at_end,
  output logic [BYTE_W-1:0] o_word
);

  localparam int IDX_W = nash_idx_w(BYTE_W);
  localparam logic [IDX_W-1:0] IDX_END = IDX_W'(BYTE_W - 1);

  logic [BYTE_W-1:0] r_shift;
  logic [BYTE_W-2:0] r_coll;
  logic [IDX_W-1:0]  r_idx;
  logic              r_last;
  logic              w_at_end;

  assign w_at_end = (r_idx == IDX_END);
  assign o_at_end = w_at_end;
  assign o_pt_bit = r_shift[0];
  assign o_last   = r_last;
  // The top bit is never stored: it is the cipher bit arriving on the final cycle.
  assign o_word   = {i_ct_bit, r_coll};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_coll  <= '0;
      r_idx   <= '0;
      r_last  <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_data;
      r_last  <= i_last;
      r_idx   <= '0;
    end else if (i_shift) begin
      r_shift <= r_shift >> 1;
      if (!w_at_end) begin
        r_coll[r_idx] <= i_ct_bit;
      end
      r_idx <= w_at_end ? '0 : r_idx + IDX_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/nash_byte_stream.sv
// nash_byte_stream: streams plaintext bytes bit-serially through an external cipher core
// and reassembles the returned cipher bits into output bytes.
`default_nettype none

module nash_byte_stream
  import nash_pkg::*;
#(
  parameter int BYTE_W = NASH_BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_load,
  input  logic [BYTE_W-1:0] key_in,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_last,
  output logic              pt_bit,
  input  logic              ct_bit,
  output logic              cipher_rst_n,
  output logic [BYTE_W-1:0] key_out,
  output logic              busy,
  output logic              err_underrun,
  output logic              err_overflow
);

  nash_state_e       r_state;
  nash_state_e       w_next;
  logic [BYTE_W-1:0] r_key;
  logic [BYTE_W-1:0] r_m_data;
  logic              r_m_valid;
  logic              r_m_last;
  logic              r_cipher_rst_n;
  logic              r_err_underrun;
  logic              r_err_overflow;

  logic [BYTE_W-1:0] w_word;
  logic              w_pt;
  logic              w_last;
  logic              w_idx_end;
  logic              w_run;
  logic              w_at_end;
  logic              w_s_ready;
  logic              w_accept;
  logic              w_underrun;
  logic              w_emit;
  logic              w_overflow;
  logic              w_load_m;

  assign w_run      = (r_state == ST_RUN);
  assign w_at_end   = w_run && w_idx_end;
  assign w_s_ready  = !w_run || (w_at_end && !w_last);
  assign w_accept   = s_valid && w_s_ready;
  assign w_underrun = w_at_end && !w_last && !s_valid;
  assign w_emit     = w_at_end && !w_underrun;
  assign w_overflow = w_emit && r_m_valid && !m_ready;
  assign w_load_m   = w_emit && !w_overflow;

  nash_byte_shifter #(
    .BYTE_W (BYTE_W)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_accept),
    .i_shift  (w_run),
    .i_data   (s_data),
    .i_last   (s_last),
    .i_ct_bit (ct_bit),
    .o_pt_bit (w_pt),
    .o_last   (w_last),
    .o_at_end (w_idx_end),
    .o_word   (w_word)
  );

  // A byte boundary keeps running only when the next byte is taken and the output slot is free.
  always_comb begin
    w_next = r_state;
    if (!w_run) begin
      if (w_accept) begin
        w_next = ST_RUN;
      end
    end else if (w_at_end) begin
      w_next = (w_accept && !w_overflow) ? ST_RUN : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_cipher_rst_n <= 1'b0;
      r_key          <= '0;
      r_m_valid      <= 1'b0;
      r_m_data       <= '0;
      r_m_last       <= 1'b0;
      r_err_underrun <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cipher_rst_n <= (w_next == ST_RUN);
      r_err_underrun <= w_underrun;
      r_err_overflow <= w_overflow;
      if (!w_run && key_load) begin
        r_key <= key_in;
      end
      if (w_load_m) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_word;
        r_m_last  <= w_last;
      end else if (r_m_valid && m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready      = w_s_ready;
  assign m_valid      = r_m_valid;
  assign m_data       = r_m_data;
  assign m_last       = r_m_last;
  assign pt_bit       = w_run & w_pt;
  assign cipher_rst_n = r_cipher_rst_n;
  assign key_out      = r_key;
  assign busy         = w_run;
  assign err_underrun = r_err_underrun;
  assign err_overflow = r_err_overflow;

endmodule

`default_nettype wire

// File: tb/tb_nash_byte_stream.sv
// tb_nash_byte_stream: directed and randomized checks against a byte-level scoreboard.
`default_nettype none

module tb_nash_byte_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_load;
  logic [7:0] key_in;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       pt_bit;
  logic       ct_bit;
  logic       cipher_rst_n;
  logic [7:0] key_out;
  logic       busy;
  logic       err_underrun;
  logic       err_overflow;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0] stub_mode;
  logic [2:0] tb_pos;
  logic       w_stub_mask;
  logic [7:0] model_key;
  logic [7:0] msg [0:7];
  bit         exp_pt [$];
  logic [8:0] exp_m [$];
  bit         mon_en;
  int         run_len = 0;
  int         last_run = 0;
  logic [7:0] last_m_data;

  always #5 clk = ~clk;

  nash_byte_stream #(.BYTE_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_load     (key_load),
    .key_in       (key_in),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .pt_bit       (pt_bit),
    .ct_bit       (ct_bit),
    .cipher_rst_n (cipher_rst_n),
    .key_out      (key_out),
    .busy         (busy),
    .err_underrun (err_underrun),
    .err_overflow (err_overflow)
  );

  // Cipher stub: identity, XOR with the key bit of the current position, or inversion.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_pos <= 3'd0;
    else if (busy) tb_pos <= tb_pos + 3'd1;
    else tb_pos <= 3'd0;
  end

  always_comb begin
    w_stub_mask = 1'b0;
    if (stub_mode == 2'd1) w_stub_mask = key_out[tb_pos];
    else if (stub_mode == 2'd2) w_stub_mask = 1'b1;
  end
  assign ct_bit = pt_bit ^ w_stub_mask;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] cipher_of(input logic [7:0] b);
    case (stub_mode)
      2'd1:    return b ^ model_key;
      2'd2:    return ~b;
      default: return b;
    endcase
  endfunction

  task automatic send_msg(input int n, input bit final_last, input bit push_m);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      bit         lst;
      int         w;
      b   = msg[i];
      lst = (i == n - 1) && final_last;
      s_valid = 1'b1;
      s_data  = b;
      s_last  = lst;
      for (int k = 0; k < 8; k++) exp_pt.push_back(b[k]);
      if (push_m) exp_m.push_back({lst, cipher_of(b)});
      w = 0;
      while (!s_ready && w < 40) begin
        tick();
        w++;
      end
      if (!s_ready) chk("s_handshake_timeout", s_ready, 1);
      tick();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = 8'h00;
  endtask

  task automatic wait_busy_low();
    int w;
    w = 0;
    while (busy && w < 60) begin
      tick();
      w++;
    end
    chk("busy_drop", busy, 0);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((busy || (m_valid && m_ready)) && w < 80) begin
      tick();
      w++;
    end
    chk("drain", busy, 0);
  endtask

  // Scoreboard: serial plaintext bit order and output byte order.
  always @(negedge clk) begin
    if (busy) run_len <= run_len + 1;
    else if (run_len > 0) begin
      last_run <= run_len;
      run_len  <= 0;
    end
    if (mon_en && rst_n) begin
      if (busy) begin
        if (exp_pt.size() == 0) chk("pt_unexpected", busy, 0);
        else chk("pt_bit", pt_bit, exp_pt.pop_front());
      end else begin
        chk("pt_idle", pt_bit, 0);
      end
      if (m_valid && m_ready) begin
        if (exp_m.size() == 0) chk("m_unexpected", m_valid, 0);
        else begin
          logic [8:0] e;
          e = exp_m.pop_front();
          chk("m_data", m_data, e[7:0]);
          chk("m_last", m_last, e[8]);
          last_m_data = m_data;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_hi;
    int mv_at;
    bit mv_seen;
    rst_n = 1'b0; key_load = 1'b0; key_in = 8'h00; s_valid = 1'b0; s_data = 8'h00;
    s_last = 1'b0; m_ready = 1'b1; stub_mode = 2'd0; model_key = 8'h00; mon_en = 1'b1;
    repeat (3) tick();
    chk("rst_cipher_rst_n", cipher_rst_n, 0);
    chk("rst_key_out", key_out, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_pt_bit", pt_bit, 0);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_underrun, err_overflow}, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    tick();

    // Key load and single-byte latency
    key_in = 8'hA5; key_load = 1'b1; tick(); key_load = 1'b0; model_key = 8'hA5;
    chk("key_out_load", key_out, 8'hA5);
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 8'h3C; s_last = 1'b1;
    for (int k = 0; k < 8; k++) exp_pt.push_back(s_data[k]);
    exp_m.push_back({1'b1, 8'h3C});
    tick();
    s_valid = 1'b0; s_last = 1'b0;
    rst_hi = 0; mv_at = 0;
    for (int c = 1; c <= 10; c++) begin
      if (cipher_rst_n) rst_hi++;
      if (m_valid && mv_at == 0) mv_at = c;
      if (c < 10) tick();
    end
    chk("cipher_rst_hi_cycles", rst_hi, 8);
    chk("latency_m_valid", mv_at, 9);
    chk("single_m_data", m_data, 8'h3C);
    chk("single_m_last", m_last, 1);
    chk("single_key_out", key_out, 8'hA5);
    m_ready = 1'b1;
    tick();
    chk("single_m_cleared", m_valid, 0);

    // Back-to-back bytes with no gaps; key_load ignored in RUN
    msg[0] = 8'h01; msg[1] = 8'h80; msg[2] = 8'hFF;
    send_msg(3, 1'b1, 1'b1);
    key_in = 8'h99; key_load = 1'b1; tick(); key_load = 1'b0;
    chk("key_ignored_in_run", key_out, 8'hA5);
    wait_drain();
    tick();
    chk("b2b_contiguous_run", last_run, 24);

    // Inverting stub
    stub_mode = 2'd2;
    msg[0] = 8'h55;
    send_msg(1, 1'b1, 1'b1);
    wait_drain();
    tick();
    chk("inv_m_data", last_m_data, 8'hAA);
    stub_mode = 2'd0;

    // Underrun on a non-last byte
    msg[0] = 8'h12;
    send_msg(1, 1'b0, 1'b0);
    wait_busy_low();
    chk("underrun_pulse", err_underrun, 1);
    chk("underrun_cipher_rst", cipher_rst_n, 0);
    chk("underrun_no_m_valid", m_valid, 0);
    tick();
    chk("underrun_one_cycle", err_underrun, 0);
    chk("underrun_still_no_m", m_valid, 0);

    // Overflow with downstream stalled
    m_ready = 1'b0;
    msg[0] = 8'h01; msg[1] = 8'h02;
    send_msg(2, 1'b1, 1'b0);
    exp_m.push_back({1'b0, 8'h01});
    wait_busy_low();
    chk("overflow_pulse", err_overflow, 1);
    chk("overflow_keep_data", m_data, 8'h01);
    chk("overflow_keep_valid", m_valid, 1);
    chk("overflow_keep_last", m_last, 0);
    chk("overflow_cipher_rst", cipher_rst_n, 0);
    tick();
    chk("overflow_one_cycle", err_overflow, 0);
    m_ready = 1'b1;
    tick();
    chk("overflow_drained", m_valid, 0);

    // Asynchronous reset mid-byte
    mon_en = 1'b0;
    msg[0] = 8'h77;
    send_msg(1, 1'b1, 1'b0);
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cipher_rst", cipher_rst_n, 0);
    chk("arst_pt_bit", pt_bit, 0);
    chk("arst_m_valid", m_valid, 0);
    chk("arst_m_data", m_data, 0);
    chk("arst_key_out", key_out, 0);
    exp_pt.delete();
    exp_m.delete();
    model_key = 8'h00;
    repeat (2) tick();
    rst_n = 1'b1;
    mv_seen = 1'b0;
    repeat (12) begin
      tick();
      if (m_valid) mv_seen = 1'b1;
    end
    chk("arst_no_partial", mv_seen, 0);
    mon_en = 1'b1;

    // Randomized messages; some start while the previous output is still pending
    for (int t = 0; t < 40; t++) begin
      int n;
      wait_busy_low();
      if ($urandom_range(0, 2) == 0) begin
        key_in = 8'($urandom);
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        model_key = key_in;
      end
      stub_mode = 2'($urandom_range(0, 2));
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) msg[i] = 8'($urandom);
      send_msg(n, 1'b1, 1'b1);
      if ($urandom_range(0, 1) == 1) wait_drain();
    end
    wait_drain();
    tick();
    chk("exp_pt_empty", exp_pt.size(), 0);
    chk("exp_m_empty", exp_m.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
